truedual_bram_param: RTL and testbench

//  Parametrised true dual-port block RAM, the successor to the fixed 1Kx16 dual-port
//  RAM. Two independent ports (A/B) on one clock, each with per-byte write enables.

---
 rtl/truedual_bram_param.sv | 172 +++++++++++++++++
 tb/tb_truedual_bram_param.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truedual_bram_param.sv
// truedual_bram_param: parametrised true dual-port block RAM on one clock with byte-lane
// write enables, selectable read-during-write, optional output register and post-reset clear.
module truedual_bram_param #(
    parameter int DATA_W   = 16,
    parameter int BYTE_W   = 8,
    parameter int ADDR_W   = 10,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0,
    parameter int COLL_PRI = 0,
    parameter int INIT_CLR = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrena,
    input  logic                     rdena,
    input  logic [DATA_W/BYTE_W-1:0] bea,
    input  logic [ADDR_W-1:0]        addra,
    input  logic [DATA_W-1:0]        dina,
    output logic [DATA_W-1:0]        douta,
    output logic                     valida,
    input  logic                     wrenb,
    input  logic                     rdenb,
    input  logic [DATA_W/BYTE_W-1:0] beb,
    input  logic [ADDR_W-1:0]        addrb,
    input  logic [DATA_W-1:0]        dinb,
    output logic [DATA_W-1:0]        doutb,
    output logic                     validb,
    output logic                     init_busy,
    output logic                     collision,
    output logic [15:0]              coll_cnt
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic [NB-1:0]     lane_a, lane_b, overlap;
    logic [NB-1:0]     lane_a_eff, lane_b_eff;
    logic              rd_a, rd_b;
    logic              s1_vld_a, s1_vld_b;
    logic [DATA_W-1:0] s1_dat_a, s1_dat_b;

    // Overlays the enabled lanes of din onto an old word (write-first read data).
    function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_word,
                                                      input logic [DATA_W-1:0] din,
                                                      input logic [NB-1:0]     en);
        logic [DATA_W-1:0] word;
        word = old_word;
        for (int i = 0; i < NB; i++)
            if (en[i]) word[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
        return word;
    endfunction

    // ---------------------------------------------------------------- control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= (INIT_CLR != 0) ? ST_CLEAR : ST_RUN;
            clr_addr <= '0;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers see pre-edge values.
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        case (state)
            ST_CLEAR: begin
                clr_addr_nxt = clr_addr + 1'b1;
                if (&clr_addr) state_nxt = ST_RUN;
            end
            default: ;
        endcase
    end

    assign init_busy = (state == ST_CLEAR);
    assign run       = (state == ST_RUN) && !rst;

    // ---------------------------------------------------------------- write arbitration
    assign lane_a  = (run && wrena) ? bea : '0;
    assign lane_b  = (run && wrenb) ? beb : '0;
    assign overlap = (addra == addrb) ? (lane_a & lane_b) : '0;

    // The losing port simply drops its overlapping lanes, so the two write paths never conflict.
    assign lane_a_eff = (COLL_PRI == 1) ? (lane_a & ~overlap) : lane_a;
    assign lane_b_eff = (COLL_PRI == 1) ? lane_b : (lane_b & ~overlap);

    // NOTE: the array has no reset branch; zeroing is a separate FSM phase so it still maps to block RAM.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_CLEAR) mem[clr_addr] <= '0;
        for (int i = 0; i < NB; i++) begin
            if (lane_a_eff[i]) mem[addra][i*BYTE_W +: BYTE_W] <= dina[i*BYTE_W +: BYTE_W];
            if (lane_b_eff[i]) mem[addrb][i*BYTE_W +: BYTE_W] <= dinb[i*BYTE_W +: BYTE_W];
        end
    end

    // ---------------------------------------------------------------- read path
    // No-change mode suppresses a read that coincides with a write request on the same port.
    assign rd_a = run && rdena && !(RDW_MODE == 2 && wrena);
    assign rd_b = run && rdenb && !(RDW_MODE == 2 && wrenb);

    // Write-first data reflects only the reading port's own lanes; cross-port reads see the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_a <= 1'b0;
            s1_vld_b <= 1'b0;
            s1_dat_a <= '0;
            s1_dat_b <= '0;
        end else begin
            s1_vld_a <= rd_a;
            s1_vld_b <= rd_b;
            if (rd_a)
                s1_dat_a <= (RDW_MODE == 1) ? merge_lanes(mem[addra], dina, wrena ? bea : '0)
                                            : mem[addra];
            if (rd_b)
                s1_dat_b <= (RDW_MODE == 1) ? merge_lanes(mem[addrb], dinb, wrenb ? beb : '0)
                                            : mem[addrb];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              s2_vld_a, s2_vld_b;
            logic [DATA_W-1:0] s2_dat_a, s2_dat_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_vld_a <= 1'b0;
                    s2_vld_b <= 1'b0;
                    s2_dat_a <= '0;
                    s2_dat_b <= '0;
                end else begin
                    s2_vld_a <= s1_vld_a;
                    s2_vld_b <= s1_vld_b;
                    if (s1_vld_a) s2_dat_a <= s1_dat_a;
                    if (s1_vld_b) s2_dat_b <= s1_dat_b;
                end
            end

            assign douta  = s2_dat_a;
            assign valida = s2_vld_a;
            assign doutb  = s2_dat_b;
            assign validb = s2_vld_b;
        end else begin : g_no_out_reg
            assign douta  = s1_dat_a;
            assign valida = s1_vld_a;
            assign doutb  = s1_dat_b;
            assign validb = s1_vld_b;
        end
    endgenerate

    // ---------------------------------------------------------------- collision reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            collision <= 1'b0;
            coll_cnt  <= '0;
        end else begin
            collision <= |overlap;
            if (|overlap && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_truedual_bram_param.sv
// tb_truedual_bram_param: random stimulus against a behavioural memory model, plus
// hand-computed scenarios for clear timing, collisions, read-during-write and byte lanes.
module tb_truedual_bram_param;

    localparam int DATA_W   = 16;
    localparam int BYTE_W   = 8;
    localparam int ADDR_W   = 10;
    localparam int RDW_MODE = 0;
    localparam int OUT_REG  = 0;
    localparam int COLL_PRI = 0;
    localparam int INIT_CLR = 1;
    localparam int NB       = DATA_W / BYTE_W;
    localparam int DEPTH    = 2 ** ADDR_W;

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
    } rd_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wrena = 1'b0, rdena = 1'b0, wrenb = 1'b0, rdenb = 1'b0;
    logic [NB-1:0]     bea = '0, beb = '0;
    logic [ADDR_W-1:0] addra = '0, addrb = '0;
    logic [DATA_W-1:0] dina = '0, dinb = '0;
    logic [DATA_W-1:0] douta, doutb;
    logic              valida, validb, init_busy, collision;
    logic [15:0]       coll_cnt;

    truedual_bram_param #(
        .DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W), .RDW_MODE(RDW_MODE),
        .OUT_REG(OUT_REG), .COLL_PRI(COLL_PRI), .INIT_CLR(INIT_CLR)
    ) dut (
        .clk(clk), .rst(rst),
        .wrena(wrena), .rdena(rdena), .bea(bea), .addra(addra), .dina(dina),
        .douta(douta), .valida(valida),
        .wrenb(wrenb), .rdenb(rdenb), .beb(beb), .addrb(addrb), .dinb(dinb),
        .doutb(doutb), .validb(validb),
        .init_busy(init_busy), .collision(collision), .coll_cnt(coll_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- behavioural model
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                clr_left = 0;
    rd_t               pipe_a[$], pipe_b[$];
    logic [DATA_W-1:0] exp_dout_a = '0, exp_dout_b = '0;
    logic              exp_vld_a = 1'b0, exp_vld_b = 1'b0, exp_coll = 1'b0;
    logic [15:0]       exp_cnt = '0;
    bit                chk_en = 1'b0;

    function automatic logic [DATA_W-1:0] overlay(input logic [DATA_W-1:0] w,
                                                  input logic [DATA_W-1:0] d,
                                                  input logic [NB-1:0] en);
        for (int i = 0; i < NB; i++)
            if (en[i]) w[i*BYTE_W +: BYTE_W] = d[i*BYTE_W +: BYTE_W];
        return w;
    endfunction

    task automatic port_read(input logic rden, input logic wren, input logic [NB-1:0] be,
                             input logic [DATA_W-1:0] din, input logic [DATA_W-1:0] old,
                             output rd_t r);
        r.v = rden && !(RDW_MODE == 2 && wren);
        r.d = (RDW_MODE == 1 && wren) ? overlay(old, din, be) : old;
    endtask

    task automatic advance(ref rd_t q[$], input rd_t r, inout logic [DATA_W-1:0] dout,
                           output logic vld);
        rd_t o;
        q.push_back(r);
        o   = q.pop_front();
        vld = o.v;
        if (o.v) dout = o.d;
    endtask

    // Called once after each rising edge with the inputs that edge sampled.
    task automatic model_step();
        rd_t               ra, rb;
        logic [DATA_W-1:0] old_a, old_b;
        logic [NB-1:0]     ov;
        if (rst) begin
            clr_left   = (INIT_CLR != 0) ? DEPTH : 0;
            exp_dout_a = '0; exp_dout_b = '0;
            exp_vld_a  = 1'b0; exp_vld_b = 1'b0;
            exp_coll   = 1'b0; exp_cnt = '0;
            pipe_a = {}; pipe_b = {};
            repeat (OUT_REG) begin
                pipe_a.push_back('{1'b0, '0});
                pipe_b.push_back('{1'b0, '0});
            end
            chk_en = 1'b1;
            return;
        end
        ra = '{1'b0, '0};
        rb = '{1'b0, '0};
        exp_coll = 1'b0;
        if (clr_left > 0) begin
            ref_mem[DEPTH - clr_left] = '0;
            clr_left--;
        end else begin
            old_a = ref_mem[addra];
            old_b = ref_mem[addrb];
            port_read(rdena, wrena, bea, dina, old_a, ra);
            port_read(rdenb, wrenb, beb, dinb, old_b, rb);
            ov = (wrena && wrenb && addra == addrb) ? (bea & beb) : '0;
            exp_coll = (ov != 0);
            if (exp_coll && exp_cnt != 16'hFFFF) exp_cnt++;
            // Loser writes first, winner overwrites the shared lanes.
            if (COLL_PRI == 0) begin
                if (wrenb) ref_mem[addrb] = overlay(ref_mem[addrb], dinb, beb);
                if (wrena) ref_mem[addra] = overlay(ref_mem[addra], dina, bea);
            end else begin
                if (wrena) ref_mem[addra] = overlay(ref_mem[addra], dina, bea);
                if (wrenb) ref_mem[addrb] = overlay(ref_mem[addrb], dinb, beb);
            end
        end
        advance(pipe_a, ra, exp_dout_a, exp_vld_a);
        advance(pipe_b, rb, exp_dout_b, exp_vld_b);
    endtask

    // Single compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("init_busy", 32'(init_busy), 32'(clr_left > 0));
            check("valida",    32'(valida),    32'(exp_vld_a));
            check("validb",    32'(validb),    32'(exp_vld_b));
            check("douta",     32'(douta),     32'(exp_dout_a));
            check("doutb",     32'(doutb),     32'(exp_dout_b));
            check("collision", 32'(collision), 32'(exp_coll));
            check("coll_cnt",  32'(coll_cnt),  32'(exp_cnt));
        end
    end

    // ---------------------------------------------------------------- stimulus helpers
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        wrena = 1'b0; rdena = 1'b0; wrenb = 1'b0; rdenb = 1'b0;
        bea = '0; beb = '0;
    endtask

    task automatic randomize_inputs();
        wrena = 1'($urandom_range(0, 1));
        rdena = 1'($urandom_range(0, 1));
        wrenb = 1'($urandom_range(0, 1));
        rdenb = 1'($urandom_range(0, 1));
        bea   = NB'($urandom);
        beb   = NB'($urandom);
        addra = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
        addrb = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
        dina  = DATA_W'($urandom);
        dinb  = DATA_W'($urandom);
    endtask

    // Counts cycles with init_busy high, with random requests that must all be dropped.
    task automatic measure_clear(input string name);
        int n = 0;
        while (init_busy && n < DEPTH + 8) begin
            randomize_inputs();
            cycle();
            n++;
        end
        idle();
        check(name, 32'(n), 32'(DEPTH));
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic [NB-1:0] be);
        idle();
        wrena = 1'b1; addra = a; dina = d; bea = be;
        cycle();
        idle();
    endtask

    task automatic read_ab(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        idle();
        rdena = 1'b1; addra = a; rdenb = 1'b1; addrb = b;
        cycle();
        idle();
        repeat (OUT_REG) cycle();
    endtask

    // ---------------------------------------------------------------- main sequence
    initial begin
        int                lat;
        logic [DATA_W-1:0] exp_rdw;
        logic              exp_rdw_vld;

        idle();
        rst = 1'b1;
        cycle();
        check("reset_douta",    32'(douta),    32'h0);
        check("reset_valida",   32'(valida),   32'h0);
        check("reset_coll_cnt", 32'(coll_cnt), 32'h0);
        rst = 1'b0;
        measure_clear("clear_len_first");

        // Cleared top word reads back zero; valid is a single pulse at the read latency.
        rdena = 1'b1; addra = 10'h3FF;
        cycle();
        idle();
        lat = 1;
        while (!valida && lat < 5) begin
            cycle();
            lat++;
        end
        check("t1_latency", 32'(lat), 32'(1 + OUT_REG));
        check("t1_data",    32'(douta), 32'h0000);
        cycle();
        check("t1_pulse",   32'(valida), 32'h0);

        // Disjoint cross-port writes, then crossed reads.
        wrena = 1'b1; addra = 10'd1; dina = 16'h00FF; bea = 2'b11;
        wrenb = 1'b1; addrb = 10'd0; dinb = 16'h00BB; beb = 2'b11;
        cycle();
        read_ab(10'd0, 10'd1);
        check("t2_douta",    32'(douta),    32'h00BB);
        check("t2_doutb",    32'(doutb),    32'h00FF);
        check("t2_no_coll",  32'(coll_cnt), 32'h0);

        // Full-overlap collision at the same address.
        idle();
        wrena = 1'b1; addra = 10'd5; dina = 16'h0066; bea = 2'b11;
        wrenb = 1'b1; addrb = 10'd5; dinb = 16'h0077; beb = 2'b11;
        cycle();
        idle();
        check("t3_pulse", 32'(collision), 32'h1);
        check("t3_cnt",   32'(coll_cnt),  32'h1);
        read_ab(10'd5, 10'd5);
        check("t3_winner", 32'(douta), (COLL_PRI == 0) ? 32'h0066 : 32'h0077);

        // Disjoint lanes at the same address: merged, not a collision.
        wrena = 1'b1; addra = 10'd5; dina = 16'h1166; bea = 2'b01;
        wrenb = 1'b1; addrb = 10'd5; dinb = 16'h2277; beb = 2'b10;
        cycle();
        idle();
        check("t3_lanes_no_pulse", 32'(collision), 32'h0);
        check("t3_lanes_cnt",      32'(coll_cnt),  32'h1);
        read_ab(10'd5, 10'd5);
        check("t3_lanes_data", 32'(douta), 32'h2266);

        // Same-port read during write.
        write_word(10'd6, 16'h1234, 2'b11);
        case (RDW_MODE)
            0:       begin exp_rdw = 16'h1234; exp_rdw_vld = 1'b1; end
            1:       begin exp_rdw = 16'hABCD; exp_rdw_vld = 1'b1; end
            default: begin exp_rdw = 16'h2266; exp_rdw_vld = 1'b0; end
        endcase
        wrena = 1'b1; rdena = 1'b1; addra = 10'd6; dina = 16'hABCD; bea = 2'b11;
        cycle();
        idle();
        repeat (OUT_REG) cycle();
        check("t4_rdw_data",  32'(douta),  32'(exp_rdw));
        check("t4_rdw_valid", 32'(valida), 32'(exp_rdw_vld));
        read_ab(10'd6, 10'd6);
        check("t4_stored", 32'(doutb), 32'hABCD);

        // Single upper-lane write.
        write_word(10'd7, 16'h1234, 2'b11);
        write_word(10'd7, 16'hAA55, 2'b10);
        read_ab(10'd7, 10'd7);
        check("t5_lane", 32'(douta), 32'hAA34);

        // Randomised traffic, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            rst = ($urandom_range(0, 999) == 0);
            cycle();
        end
        rst = 1'b0;
        idle();

        // Reset in the middle of a clear restarts it from address 0.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (300) begin
            randomize_inputs();
            cycle();
        end
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        measure_clear("clear_len_restart");

        // Counter saturation.
        wrena = 1'b1; addra = 10'd5; dina = 16'h0066; bea = 2'b11;
        wrenb = 1'b1; addrb = 10'd5; dinb = 16'h0077; beb = 2'b11;
        repeat (65540) cycle();
        check("t6_sat_pulse", 32'(collision), 32'h1);
        check("t6_sat_cnt",   32'(coll_cnt),  32'hFFFF);
        idle();
        cycle();
        check("t6_sat_hold",  32'(coll_cnt),  32'hFFFF);
        check("t6_pulse_end", 32'(collision), 32'h0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
